// File: rtl/force_seq_pkg.sv
// Shared types for the force/release command sequencer.
// Command opcodes, FSM states and the queued command record.
package force_seq_pkg;

  localparam int FS_WIDTH = 8;
  localparam int FS_CNT_W = 8;

  typedef enum logic [1:0] {
    OP_FORCE       = 2'd0,
    OP_RELEASE     = 2'd1,
    OP_FORCE_TIMED = 2'd2,
    OP_RSVD        = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_TIMED = 2'd2
  } state_e;

  typedef struct packed {
    op_e                 op;
    logic [FS_WIDTH-1:0] mask;
    logic [FS_WIDTH-1:0] value;
    logic [FS_CNT_W-1:0] hold;
  } cmd_t;

endpackage

// File: rtl/force_cmd_fifo.sv
// Small synchronous command FIFO with synchronous flush.
// DEPTH must be a power of two so the pointers wrap for free.
module force_cmd_fifo
  import force_seq_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = cmd_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/force_override_seq.sv
// Queued force/release sequencer producing a registered override
// of data_in; timed forces release themselves after N edges.
module force_override_seq
  import force_seq_pkg::*;
#(
  parameter int WIDTH = FS_WIDTH,
  parameter int CNT_W = FS_CNT_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_value,
  input  logic [CNT_W-1:0] cmd_hold,
  output logic [WIDTH-1:0] out_val,
  output logic [WIDTH-1:0] force_active,
  output logic             busy,
  output logic             evt_release,
  output logic             err
);

  cmd_t             cmd_in;
  cmd_t             head;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  state_e           state;
  state_e           state_n;
  logic [WIDTH-1:0] am;
  logic [WIDTH-1:0] am_n;
  logic [WIDTH-1:0] av;
  logic [WIDTH-1:0] av_n;
  logic [WIDTH-1:0] tm;
  logic [WIDTH-1:0] tm_n;
  logic [WIDTH-1:0] ov_n;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_n;
  logic             evt_n;
  logic             err_n;

  assign cmd_in = '{
    op:    op_e'(cmd_op),
    mask:  cmd_mask,
    value: cmd_value,
    hold:  cmd_hold
  };

  // Ready is held low while reset is asserted.
  assign cmd_ready    = rst_n & ~full;
  assign push         = cmd_valid & cmd_ready & ~flush;
  assign force_active = am;
  assign busy         = ~empty | (state == S_TIMED);

  force_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .din   (cmd_in),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n = state;
    am_n    = am;
    av_n    = av;
    tm_n    = tm;
    timer_n = timer;
    evt_n   = 1'b0;
    err_n   = 1'b0;
    pop     = 1'b0;
    ov_n    = (data_in & ~am) | (av & am);
    if (flush) begin
      state_n = S_IDLE;
      am_n    = '0;
      av_n    = '0;
      tm_n    = '0;
      timer_n = '0;
    end else if (state == S_TIMED) begin
      if (timer == CNT_W'(1)) begin
        am_n    = am & ~tm;
        av_n    = av & ~tm;
        tm_n    = '0;
        timer_n = '0;
        evt_n   = 1'b1;
        state_n = (am_n == '0) ? S_IDLE : S_HOLD;
      end else begin
        timer_n = timer - 1'b1;
      end
    end else if (!empty) begin
      pop = 1'b1;
      unique case (head.op)
        OP_FORCE: begin
          am_n    = am | head.mask;
          av_n    = (av & ~head.mask) | (head.value & head.mask);
          tm_n    = tm & ~head.mask;
          state_n = (am_n == '0) ? S_IDLE : S_HOLD;
        end
        OP_RELEASE: begin
          am_n    = am & ~head.mask;
          av_n    = av & ~head.mask;
          state_n = (am_n == '0) ? S_IDLE : S_HOLD;
        end
        OP_FORCE_TIMED: begin
          am_n    = am | head.mask;
          av_n    = (av & ~head.mask) | (head.value & head.mask);
          tm_n    = head.mask;
          // A zero hold still costs one edge.
          timer_n = (head.hold == '0) ? CNT_W'(1) : head.hold;
          state_n = S_TIMED;
        end
        OP_RSVD: begin
          err_n = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      am          <= '0;
      av          <= '0;
      tm          <= '0;
      timer       <= '0;
      out_val     <= '0;
      evt_release <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      am          <= am_n;
      av          <= av_n;
      tm          <= tm_n;
      timer       <= timer_n;
      out_val     <= ov_n;
      evt_release <= evt_n;
      err         <= err_n;
    end
  end

endmodule

// File: tb/tb_force_override_seq.sv
// Directed vector bench for force_override_seq: a table of
// per-edge vectors plus hand-written reset/flush sequences.
module tb_force_override_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       flush = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_mask = 8'h00;
  logic [7:0] cmd_value = 8'h00;
  logic [7:0] cmd_hold = 8'h00;
  logic [7:0] out_val;
  logic [7:0] force_active;
  logic       busy;
  logic       evt_release;
  logic       err;

  always #5 clk = ~clk;

  force_override_seq #(
    .WIDTH (8),
    .CNT_W (8),
    .DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .flush        (flush),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_mask     (cmd_mask),
    .cmd_value    (cmd_value),
    .cmd_hold     (cmd_hold),
    .out_val      (out_val),
    .force_active (force_active),
    .busy         (busy),
    .evt_release  (evt_release),
    .err          (err)
  );

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic [1:0] op;
    logic [7:0] m;
    logic [7:0] val;
    logic [7:0] h;
    logic       fl;
    logic [7:0] out;
    logic [7:0] act;
    logic       rdy;
    logic       bsy;
    logic       evt;
    logic       er;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(string nm, int idx,
                     logic [7:0] a, logic [7:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h, expected %h",
               nm, idx, a, e);
    end
  endtask

  task automatic add(logic [7:0] d, logic v, logic [1:0] op,
                     logic [7:0] m, logic [7:0] val,
                     logic [7:0] h, logic fl,
                     logic [7:0] out, logic [7:0] act,
                     logic rdy, logic bsy, logic evt,
                     logic er);
    vec_t t;
    t.d = d; t.v = v; t.op = op; t.m = m;
    t.val = val; t.h = h; t.fl = fl;
    t.out = out; t.act = act; t.rdy = rdy;
    t.bsy = bsy; t.evt = evt; t.er = er;
    tv.push_back(t);
  endtask

  task automatic drive(logic [7:0] d, logic v, logic [1:0] op,
                       logic [7:0] m, logic [7:0] val,
                       logic [7:0] h, logic fl);
    data_in   = d;
    cmd_valid = v;
    cmd_op    = op;
    cmd_mask  = m;
    cmd_value = val;
    cmd_hold  = h;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(string nm, int idx,
                          logic [7:0] out, logic [7:0] act,
                          logic rdy, logic bsy, logic evt,
                          logic er);
    chk({nm, ".out_val"}, idx, out_val, out);
    chk({nm, ".force_active"}, idx, force_active, act);
    chk({nm, ".cmd_ready"}, idx, {7'd0, cmd_ready}, {7'd0, rdy});
    chk({nm, ".busy"}, idx, {7'd0, busy}, {7'd0, bsy});
    chk({nm, ".evt_release"}, idx,
        {7'd0, evt_release}, {7'd0, evt});
    chk({nm, ".err"}, idx, {7'd0, err}, {7'd0, er});
  endtask

  initial begin
    logic seen;

    // idle pass-through
    add(8'h5A,1,0,8'h00,8'h00,0,0, 8'h5A,8'h00,1,0,0,0);
    tv[0].v = 1'b0;
    add(8'h5A,0,0,8'h00,8'h00,0,0, 8'h5A,8'h00,1,0,0,0);
    // FORCE all, then RELEASE all
    add(8'h5A,1,0,8'hFF,8'hFF,0,0, 8'h5A,8'h00,1,1,0,0);
    add(8'h5A,0,0,8'h00,8'h00,0,0, 8'h5A,8'hFF,1,0,0,0);
    add(8'h5A,0,0,8'h00,8'h00,0,0, 8'hFF,8'hFF,1,0,0,0);
    add(8'h5A,1,1,8'hFF,8'h00,0,0, 8'hFF,8'hFF,1,1,0,0);
    add(8'h5A,0,0,8'h00,8'h00,0,0, 8'hFF,8'h00,1,0,0,0);
    add(8'h5A,0,0,8'h00,8'h00,0,0, 8'h5A,8'h00,1,0,0,0);
    // FORCE_TIMED low nibble for 10 edges
    add(8'h50,1,2,8'h0F,8'h0F,10,0, 8'h50,8'h00,1,1,0,0);
    add(8'h50,0,0,8'h00,8'h00,0,0, 8'h50,8'h0F,1,1,0,0);
    for (int k = 1; k <= 9; k++)
      add(8'h50,0,0,8'h00,8'h00,0,0, 8'h5F,8'h0F,1,1,0,0);
    add(8'h50,0,0,8'h00,8'h00,0,0, 8'h5F,8'h00,1,0,1,0);
    add(8'h50,0,0,8'h00,8'h00,0,0, 8'h50,8'h00,1,0,0,0);
    // hold=0 behaves as hold=1
    add(8'h50,1,2,8'h01,8'h01,0,0, 8'h50,8'h00,1,1,0,0);
    add(8'h50,0,0,8'h00,8'h00,0,0, 8'h50,8'h01,1,1,0,0);
    add(8'h50,0,0,8'h00,8'h00,0,0, 8'h51,8'h00,1,0,1,0);
    add(8'h50,0,0,8'h00,8'h00,0,0, 8'h50,8'h00,1,0,0,0);
    // reserved op
    add(8'h50,1,3,8'hFF,8'hFF,0,0, 8'h50,8'h00,1,1,0,0);
    add(8'h50,0,0,8'h00,8'h00,0,0, 8'h50,8'h00,1,0,0,1);
    add(8'h50,0,0,8'h00,8'h00,0,0, 8'h50,8'h00,1,0,0,0);
    // stall behind a timed force, FIFO fills
    add(8'h50,1,2,8'hF0,8'hA0,3,0, 8'h50,8'h00,1,1,0,0);
    add(8'h50,1,0,8'h01,8'h01,0,0, 8'h50,8'hF0,1,1,0,0);
    add(8'h50,1,0,8'h02,8'h02,0,0, 8'hA0,8'hF0,0,1,0,0);
    add(8'h50,1,0,8'h04,8'h04,0,0, 8'hA0,8'hF0,0,1,0,0);
    add(8'h50,1,0,8'h04,8'h04,0,0, 8'hA0,8'h00,0,1,1,0);
    add(8'h50,0,0,8'h00,8'h00,0,0, 8'h50,8'h01,1,1,0,0);
    add(8'h50,0,0,8'h00,8'h00,0,0, 8'h51,8'h03,1,0,0,0);
    add(8'h50,0,0,8'h00,8'h00,0,0, 8'h53,8'h03,1,0,0,0);
    add(8'h50,1,1,8'hFF,8'h00,0,0, 8'h53,8'h03,1,1,0,0);
    add(8'h50,0,0,8'h00,8'h00,0,0, 8'h53,8'h00,1,0,0,0);
    add(8'h50,0,0,8'h00,8'h00,0,0, 8'h50,8'h00,1,0,0,0);

    // reset state
    drive(8'h5A,0,0,8'h00,8'h00,0,0);
    repeat (3) step();
    chk_outs("reset", 0, 8'h00, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (tv[i]) begin
      drive(tv[i].d, tv[i].v, tv[i].op, tv[i].m,
            tv[i].val, tv[i].h, tv[i].fl);
      step();
      chk_outs("vec", i, tv[i].out, tv[i].act,
               tv[i].rdy, tv[i].bsy, tv[i].evt, tv[i].er);
    end

    // async reset in the middle of a timed force
    drive(8'h50,1,2,8'hFF,8'h33,20,0);
    step();
    drive(8'h50,0,0,8'h00,8'h00,0,0);
    repeat (3) step();
    chk("rst_mid.pre_out", 0, out_val, 8'h33);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outs("rst_mid", 0, 8'h00, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_outs("rst_after", 0, 8'h50, 8'h00, 1, 0, 0, 0);
    seen = 1'b0;
    repeat (25) begin
      step();
      seen |= evt_release;
    end
    chk("rst_no_evt", 0, {7'd0, seen}, 8'h00);

    // flush on the expiry edge with a simultaneous push
    drive(8'h50,1,2,8'h3C,8'h24,3,0);
    step();
    drive(8'h50,0,0,8'h00,8'h00,0,0);
    step();
    step();
    chk("flush.pre_out", 0, out_val, 8'h64);
    step();
    drive(8'h50,1,0,8'h0F,8'h0F,0,1);
    step();
    chk_outs("flush_edge", 0, 8'h64, 8'h00, 1, 0, 0, 0);
    drive(8'h50,0,0,8'h00,8'h00,0,0);
    step();
    chk_outs("flush_n1", 0, 8'h50, 8'h00, 1, 0, 0, 0);
    step();
    chk_outs("flush_n2", 0, 8'h50, 8'h00, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
